// File: rtl/ssd_scan_ctrl.sv
// Purpose: time-multiplexed scan of an N-digit seven-segment display with dead-time, enable, blink and DP.
// Latency: outputs registered; an input change shows within SCAN_DIV*N_DIGITS + BLANK_CYC cycles.
// Backpressure: none; free-running scan. Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zeros.
module ssd_scan_ctrl #(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   en_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [3:0]            digit_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_DRIVE = SW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                state_q, state_nxt;
  logic [SW-1:0]         slot_cnt, slot_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [BW-1:0]         blink_cnt, blink_cnt_nxt;
  logic                  blink_phase, blink_phase_nxt;
  logic                  snap_en, snap_blink, snap_dp;
  logic                  snap_en_nxt, snap_blink_nxt, snap_dp_nxt;
  logic [3:0]            digit_nxt;
  logic                  restart;
  logic                  slot_wrap, frame_wrap, load;
  logic [3:0]            nib_sel;
  logic                  en_sel, blink_sel, dp_sel, sup_sel, lit;
  logic [N_DIGITS-1:0]   an_nxt;
  logic                  dp_nxt;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0]   sup_mask, sup_calc, sup_nxt;
  logic                  leading;
`endif

  // Counters, snapshot and next-state/output decode (outputs are registered from next-state values)
  always_comb begin
    slot_wrap       = (slot_cnt == SLOT_LAST);
    slot_nxt        = slot_wrap ? '0 : slot_cnt + 1'b1;
    idx_nxt         = idx;
    if (slot_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    frame_wrap      = slot_wrap && (idx == IDX_LAST);
    blink_cnt_nxt   = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase ^ (blink_cnt == BLINK_LAST);
    // The first slot after reset has no prior wrap, so its snapshot is taken on the restart cycle
    load            = slot_wrap || restart;

    nib_sel   = 4'h0;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    dp_sel    = 1'b0;
    sup_sel   = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib_sel   = digits_in[4*k +: 4];
        en_sel    = en_mask[k];
        blink_sel = blink_mask[k];
        dp_sel    = dp_in[k];
      end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; enabled zeros are blanked until the first enabled non-zero
    leading  = 1'b1;
    sup_calc = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (en_mask[k]) begin
        if (digits_in[4*k +: 4] == 4'h0) begin
          if (leading) sup_calc[k] = 1'b1;
        end else begin
          leading = 1'b0;
        end
      end
    end
    sup_nxt = (frame_wrap || restart) ? sup_calc : sup_mask;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) sup_sel = sup_nxt[k];
    end
`endif

    snap_en_nxt    = load ? en_sel    : snap_en;
    snap_blink_nxt = load ? blink_sel : snap_blink;
    snap_dp_nxt    = load ? dp_sel    : snap_dp;
    digit_nxt      = load ? nib_sel   : digit_out;

    state_nxt = state_q;
    case (state_q)
      BLANK:   if (slot_nxt == SLOT_DRIVE) state_nxt = DRIVE;
      DRIVE:   if (slot_wrap) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    lit    = snap_en_nxt && !(snap_blink_nxt && blink_phase_nxt) && !sup_sel;
    an_nxt = '1;
    dp_nxt = 1'b1;
    if ((state_nxt == DRIVE) && lit) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (idx_nxt == IW'(k)) an_nxt[k] = 1'b0;
      end
      dp_nxt = ~snap_dp_nxt;
    end
  end

  // State, counters, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BLANK;
      slot_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_en     <= 1'b0;
      snap_blink  <= 1'b0;
      snap_dp     <= 1'b0;
      restart     <= 1'b1;
      digit_out   <= 4'h0;
      an          <= '1;
      dp_out      <= 1'b1;
      frame_start <= 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      sup_mask    <= '0;
`endif
    end else begin
      state_q     <= state_nxt;
      slot_cnt    <= slot_nxt;
      idx         <= idx_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      snap_en     <= snap_en_nxt;
      snap_blink  <= snap_blink_nxt;
      snap_dp     <= snap_dp_nxt;
      restart     <= 1'b0;
      digit_out   <= digit_nxt;
      an          <= an_nxt;
      dp_out      <= dp_nxt;
      frame_start <= frame_wrap;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      sup_mask    <= sup_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl (N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  en_mask, blink_mask, dp_in;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        dp_out, frame_start;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .en_mask(en_mask),
    .blink_mask(blink_mask), .dp_in(dp_in), .digit_out(digit_out),
    .an(an), .dp_out(dp_out), .frame_start(frame_start)
  );

  typedef struct {
    int         stamp;
    int         scen;
    int         t;
    logic [3:0] an;
    logic [3:0] dig;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   r     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped with the current cycle
  always @(negedge clk) begin
    int   i;
    exp_t e;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].stamp <= cyc) begin
        e = sb[i];
        sb.delete(i);
        total++;
        if (e.stamp < cyc) begin
          bad++;
          $display("FAIL stale s%0d t=%0d: entry never sampled (now cyc=%0d, stamp=%0d)", e.scen, e.t, cyc, e.stamp);
        end else if ({an, digit_out, dp_out, frame_start} !== {e.an, e.dig, e.dp, e.fs}) begin
          bad++;
          $display("FAIL scan s%0d t=%0d: got an=%b dig=%h dp=%b fs=%b, want an=%b dig=%h dp=%b fs=%b",
                   e.scen, e.t, an, digit_out, dp_out, frame_start, e.an, e.dig, e.dp, e.fs);
        end
      end else begin
        i++;
      end
    end
  end

  task automatic push(input int scen, input int t, input logic [3:0] a, input logic [3:0] d,
                      input logic p, input logic f);
    exp_t e;
    e.stamp = r + t; e.scen = scen; e.t = t;
    e.an = a; e.dig = d; e.dp = p; e.fs = f;
    sb.push_back(e);
  endtask

  // Expected behaviour for constant inputs, t counted from the first cycle after reset
  task automatic push_win(input int scen, input int t0, input int t1, input logic [15:0] dig,
                          input logic [3:0] en, input logic [3:0] bl, input logic [3:0] dpm,
                          input logic [3:0] sup);
    int         slot, id;
    logic       ph, lit, drv;
    logic [3:0] one, a, d;
    logic       p, f;
    for (int t = t0; t < t1; t++) begin
      slot = t % 8;
      id   = (t / 8) % 4;
      ph   = ((t / 64) % 2) == 1;
      lit  = en[id] && !(bl[id] && ph) && !sup[id];
      drv  = (slot >= 2) && lit;
      one  = 4'b0001 << id;
      a    = drv ? ~one : 4'hF;
      p    = drv ? ~dpm[id] : 1'b1;
      d    = (t == 0) ? 4'h0 : dig[id*4 +: 4];
      f    = (t > 0) && (t % 32 == 0);
      push(scen, t, a, d, p, f);
    end
  endtask

  task automatic do_reset(input logic [15:0] dig, input logic [3:0] en, input logic [3:0] bl,
                          input logic [3:0] dpm);
    rst = 1'b1;
    digits_in = dig; en_mask = en; blink_mask = bl; dp_in = dpm;
    r = cyc + 1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_t(input int t);
    while (cyc < r + t) @(negedge clk);
  endtask

  logic [3:0] sup6, sup7;

  initial begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
    sup6 = 4'b1100;
    sup7 = 4'b1110;
`else
    sup6 = 4'b0000;
    sup7 = 4'b0000;
`endif
    rst = 1'b1; digits_in = 16'h0; en_mask = 4'h0; blink_mask = 4'h0; dp_in = 4'h0;
    repeat (3) @(negedge clk);

    // 1: basic scan of 4321
    do_reset(16'h4321, 4'hF, 4'h0, 4'h0);
    push_win(1, 0, 72, 16'h4321, 4'hF, 4'h0, 4'h0, 4'h0);
    push(1, 0, 4'hF, 4'h0, 1'b1, 1'b0);
    push(1, 2, 4'b1110, 4'h1, 1'b1, 1'b0);
    push(1, 10, 4'b1101, 4'h2, 1'b1, 1'b0);
    push(1, 18, 4'b1011, 4'h3, 1'b1, 1'b0);
    push(1, 26, 4'b0111, 4'h4, 1'b1, 1'b0);
    push(1, 32, 4'hF, 4'h1, 1'b1, 1'b1);
    push(1, 33, 4'hF, 4'h1, 1'b1, 1'b0);
    push(1, 64, 4'hF, 4'h1, 1'b1, 1'b1);
    release_rst();
    wait_t(71);

    // 2: mid-slot input change does not tear the current slot
    @(negedge clk);
    do_reset(16'h4321, 4'hF, 4'h0, 4'h0);
    push_win(2, 0, 16, 16'h4321, 4'hF, 4'h0, 4'h0, 4'h0);
    push_win(2, 16, 40, 16'h9999, 4'hF, 4'h0, 4'h0, 4'h0);
    push(2, 15, 4'b1101, 4'h2, 1'b1, 1'b0);
    push(2, 16, 4'hF, 4'h9, 1'b1, 1'b0);
    release_rst();
    wait_t(12);
    digits_in = 16'h9999;
    wait_t(39);

    // 3: digit 1 blinks
    @(negedge clk);
    do_reset(16'h4321, 4'hF, 4'b0010, 4'h0);
    push_win(3, 0, 200, 16'h4321, 4'hF, 4'b0010, 4'h0, 4'h0);
    push(3, 10, 4'b1101, 4'h2, 1'b1, 1'b0);
    push(3, 74, 4'hF, 4'h2, 1'b1, 1'b0);
    push(3, 82, 4'b1011, 4'h3, 1'b1, 1'b0);
    push(3, 138, 4'b1101, 4'h2, 1'b1, 1'b0);
    release_rst();
    wait_t(199);

    // 4: partial enable and decimal point
    @(negedge clk);
    do_reset(16'h4321, 4'b0101, 4'h0, 4'b0001);
    push_win(4, 0, 64, 16'h4321, 4'b0101, 4'h0, 4'b0001, 4'h0);
    push(4, 2, 4'b1110, 4'h1, 1'b0, 1'b0);
    push(4, 10, 4'hF, 4'h2, 1'b1, 1'b0);
    push(4, 18, 4'b1011, 4'h3, 1'b1, 1'b0);
    push(4, 26, 4'hF, 4'h4, 1'b1, 1'b0);
    release_rst();
    wait_t(63);

    // 5: reset during digit 2's DRIVE restarts the scan at digit 0
    @(negedge clk);
    do_reset(16'h4321, 4'hF, 4'h0, 4'h0);
    push_win(5, 0, 20, 16'h4321, 4'hF, 4'h0, 4'h0, 4'h0);
    release_rst();
    wait_t(19);
    do_reset(16'h4321, 4'hF, 4'h0, 4'h0);
    push_win(5, 0, 40, 16'h4321, 4'hF, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'hF, 4'h0, 1'b1, 1'b0);
    push(5, 2, 4'b1110, 4'h1, 1'b1, 1'b0);
    push(5, 32, 4'hF, 4'h1, 1'b1, 1'b1);
    release_rst();
    wait_t(39);

    // 6: 0050 (leading zeros blanked only when the option is built in)
    @(negedge clk);
    do_reset(16'h0050, 4'hF, 4'h0, 4'h0);
    push_win(6, 0, 40, 16'h0050, 4'hF, 4'h0, 4'h0, sup6);
    push(6, 2, 4'b1110, 4'h0, 1'b1, 1'b0);
    push(6, 10, 4'b1101, 4'h5, 1'b1, 1'b0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    push(6, 18, 4'hF, 4'h0, 1'b1, 1'b0);
    push(6, 26, 4'hF, 4'h0, 1'b1, 1'b0);
`else
    push(6, 18, 4'b1011, 4'h0, 1'b1, 1'b0);
    push(6, 26, 4'b0111, 4'h0, 1'b1, 1'b0);
`endif
    release_rst();
    wait_t(39);

    // 7: all zeros
    @(negedge clk);
    do_reset(16'h0000, 4'hF, 4'h0, 4'h0);
    push_win(7, 0, 40, 16'h0000, 4'hF, 4'h0, 4'h0, sup7);
    push(7, 2, 4'b1110, 4'h0, 1'b1, 1'b0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    push(7, 10, 4'hF, 4'h0, 1'b1, 1'b0);
`else
    push(7, 10, 4'b1101, 4'h0, 1'b1, 1'b0);
`endif
    release_rst();
    wait_t(39);

    // 8: all digits disabled, scan and frame_start keep running
    @(negedge clk);
    do_reset(16'h4321, 4'h0, 4'h0, 4'hF);
    push_win(8, 0, 40, 16'h4321, 4'h0, 4'h0, 4'hF, 4'h0);
    push(8, 2, 4'hF, 4'h1, 1'b1, 1'b0);
    push(8, 32, 4'hF, 4'h1, 1'b1, 1'b1);
    release_rst();
    wait_t(39);

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the multi-digit seven-segment display on the alarm clock board.
- Walks the digit positions in turn. For each slot it presents one 4-bit nibble to the per-digit segment encoder and drives the matching active-low anode.
- Inserts a dead-time between slots to prevent ghosting.
- Supports per-digit enable, per-digit blink (used by the time-set and alarm-set modes), and decimal points.

Parameters:
- N_DIGITS, 8, number of digit positions scanned (≥2).
- SCAN_DIV, 100000, clk cycles per digit slot (≥4).
- BLANK_CYC, 16, dead-time cycles at the start of each slot, all anodes off (1 ≤ BLANK_CYC < SCAN_DIV).
- BLINK_DIV, 25000000, clk cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- digits_in  in  4*N_DIGITS  packed nibbles; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- en_mask  in  N_DIGITS  1 = digit k may light.
- blink_mask  in  N_DIGITS  1 = digit k blinks.
- dp_in  in  N_DIGITS  1 = decimal point of digit k lit.
- digit_out  out  4  nibble to the segment encoder, registered.
- an  out  N_DIGITS  anode selects, active-low, registered.
- dp_out  out  1  decimal point, active-low, registered.
- frame_start  out  1  one-cycle pulse when the scan index wraps to digit 0.

Behaviour:
- Reset (sync, active-high, one clk edge with rst=1):
  - slot_cnt=0, idx=0, state=BLANK, blink_phase=0.
  - an=all 1s, digit_out=4'h0, dp_out=1, frame_start=0.
  - rst has priority over every other event. Reset mid-slot or mid-frame abandons the scan; scanning restarts at digit 0 on the first cycle after rst deasserts.
- Slot counter:
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, idx increments modulo N_DIGITS (N_DIGITS-1 → 0).
- Snapshot:
  - On the cycle slot_cnt becomes 0, latch digits_in[idx], en_mask[idx], blink_mask[idx] and dp_in[idx] for the new idx.
  - Input changes mid-slot do not affect the current slot (no tearing).
  - digit_out updates from the snapshot at slot start and holds for the whole slot.
- FSM, two states:
  - BLANK while slot_cnt < BLANK_CYC: an=all 1s, dp_out=1.
  - DRIVE while slot_cnt ≥ BLANK_CYC.
  - an[idx]=0 only if snap_en=1 and not (snap_blink=1 and blink_phase=1). All other anode bits stay 1.
  - dp_out = ~(snap_dp) under the same lit condition, else 1.
  - BLANK→DRIVE when slot_cnt reaches BLANK_CYC. DRIVE→BLANK on slot_cnt wrap.
  - At most one anode is low in any cycle; anodes never overlap across a slot boundary.
- Blink:
  - Free-running counter; blink_phase toggles every BLINK_DIV cycles.
  - Phase 0 = visible. Independent of the scan position.
- frame_start:
  - Asserted for exactly one cycle, coincident with the first BLANK cycle of digit 0's slot.
  - Not asserted on the first slot after reset.
- Latency: an input change is visible at most SCAN_DIV*N_DIGITS + BLANK_CYC cycles later.
- All-disabled (en_mask=0): scanning, counters and frame_start still run; an stays all 1s.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined:
  - At each frame_start, compute a suppression mask from digits_in and en_mask.
  - Starting at digit N_DIGITS-1 and going down, each enabled digit with nibble 4'h0 is suppressed until the first non-zero enabled digit.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its anode and dp high for the whole frame.
  - The mask holds for the whole frame.
- Undefined: no suppression; zeros display normally.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
- Reset, then digits_in=16'h4321, en_mask=4'hF, masks 0 → per slot: 2 cycles an=4'hF, then 6 cycles an=1110/1101/1011/0111 with digit_out=1/2/3/4; frame_start pulses every 32 cycles.
- Change digits_in to 16'h9999 at slot_cnt=4 of digit 1's slot → digit_out stays 2 until that slot ends; 9 appears from the next slot.
- blink_mask=4'b0010 → digit 1's anode is low only during blink_phase=0 windows (64 cycles on, 64 off); the other digits are unaffected.
- en_mask=4'b0101, dp_in=4'b0001 → only an[0] and an[2] ever go low; dp_out=0 only during digit 0's DRIVE cycles.
- Assert rst for 1 cycle during digit 2's DRIVE → next cycle an=4'hF, digit_out=0; digit 0 is driven at slot_cnt=2; no frame_start on that first slot.
- With SSD_LEADING_ZERO_BLANK_EN: digits_in=16'h0050 → an[3] stays high, digits 2,1,0 lit (showing 5,0 at digits 1,0 and 0 at digit 2 not suppressed? no: digit 2 is 0 above the first non-zero, so suppressed). Required: an[3] and an[2] stay high; digit 1 shows 5; digit 0 shows 0. digits_in=16'h0000 → only digit 0 lit.
